regfile_param: RTL and testbench

- Parametrised successor to the processor's fixed 8×16-bit register bank.
- Holds NUM_REGS general-purpose registers plus two special registers, C and S.
- Provides one byte-maskable write port and two combinational read ports, with optional write-to-read bypass and an optional hard-zero R0.
- Sits between decode/execute and writeback in the processor datapath. A flat dump bus feeds the debug/trace logic.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_word.sv | 19 +
 rtl/regfile_param.sv | 67 ++++++
 tb/tb_regfile_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and byte-merge function for the register file
package regfile_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int MAX_W        = 512;
    localparam int MAX_BE       = MAX_W / 8;

    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0] old_v,
                                               input logic [MAX_W-1:0] new_v,
                                               input logic [MAX_BE-1:0] be);
        logic [MAX_W-1:0] r;
        for (int k = 0; k < MAX_BE; k++) r[k*8 +: 8] = be[k] ? new_v[k*8 +: 8] : old_v[k*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/regfile_word.sv
// regfile_word: one register with sync reset, byte-enabled load and a merged next-value output
module regfile_word
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_W-1:0]   d,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   q,
    output logic [DATA_W-1:0]   merged
);
    assign merged = DATA_W'(merge(MAX_W'(q), MAX_W'(d), MAX_BE'(be)));

    always_ff @(posedge clk)
        q <= rst ? '0 : en ? merged : q;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised GPR bank with byte-masked write, two read ports, optional bypass/zero-R0, and C/S registers
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_R0  = 1'b0,
    localparam int AW      = addr_w(NUM_REGS),
    localparam int BW      = DATA_W / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [BW-1:0]                wbe,
    input  logic [AW-1:0]                raddr_a,
    output logic [DATA_W-1:0]            rdata_a,
    input  logic [AW-1:0]                raddr_b,
    output logic [DATA_W-1:0]            rdata_b,
    input  logic                         c_we,
    input  logic [DATA_W-1:0]            c_in,
    input  logic                         s_we,
    input  logic [DATA_W-1:0]            s_in,
    output logic [DATA_W-1:0]            reg_c_out,
    output logic [DATA_W-1:0]            reg_s_out,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);
    localparam int NS = 1 << AW;
    logic [DATA_W-1:0] stored [NS];
    logic [DATA_W-1:0] merged [NS];
    logic [NS-1:0]     wen;
    logic [NS-1:0]     ok;
    logic [DATA_W-1:0] c_unused;
    logic [DATA_W-1:0] s_unused;
    genvar i;
    // Address space padded to a power of two so out-of-range addresses index zero entries
    for (i = 0; i < NS; i++) begin : g_reg
        if (i < NUM_REGS) begin : g_live
            assign wen[i] = we && waddr == AW'(i) && !(ZERO_R0 && i == 0);
            assign ok[i]  = !(ZERO_R0 && i == 0);
            regfile_word #(.DATA_W(DATA_W)) u_word (
                .clk(clk), .rst(rst), .en(wen[i]), .d(wdata), .be(wbe),
                .q(stored[i]), .merged(merged[i])
            );
            assign regs_flat[i*DATA_W +: DATA_W] = stored[i];
        end else begin : g_pad
            assign wen[i]    = 1'b0;
            assign ok[i]     = 1'b0;
            assign stored[i] = '0;
            assign merged[i] = '0;
        end
    end

    assign rdata_a = !ok[raddr_a] ? '0 : (BYPASS && wen[raddr_a]) ? merged[raddr_a] : stored[raddr_a];
    assign rdata_b = !ok[raddr_b] ? '0 : (BYPASS && wen[raddr_b]) ? merged[raddr_b] : stored[raddr_b];

    regfile_word #(.DATA_W(DATA_W)) u_c (
        .clk(clk), .rst(rst), .en(c_we), .d(c_in), .be({BW{1'b1}}),
        .q(reg_c_out), .merged(c_unused)
    );
    regfile_word #(.DATA_W(DATA_W)) u_s (
        .clk(clk), .rst(rst), .en(s_we), .d(s_in), .be({BW{1'b1}}),
        .q(reg_s_out), .merged(s_unused)
    );
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: checks a default instance and a 6-reg/no-bypass/zero-R0 instance against a behavioural model
module tb_regfile_param;
    logic        clk = 0;
    logic        rst, we, c_we, s_we;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic [15:0] wdata, c_in, s_in;
    logic [1:0]  wbe;
    logic [15:0] rdata_a0, rdata_b0, c0, s0, rdata_a1, rdata_b1, c1, s1;
    logic [127:0] flat0;
    logic [95:0]  flat1;
    logic [15:0] m0 [8];
    logic [15:0] m1 [6];
    logic [15:0] mc, ms;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rdata_a0), .raddr_b(raddr_b), .rdata_b(rdata_b0),
        .c_we(c_we), .c_in(c_in), .s_we(s_we), .s_in(s_in),
        .reg_c_out(c0), .reg_s_out(s0), .regs_flat(flat0)
    );
    regfile_param #(.DATA_W(16), .NUM_REGS(6), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1),
        .c_we(c_we), .c_in(c_in), .s_we(s_we), .s_in(s_in),
        .reg_c_out(c1), .reg_s_out(s1), .regs_flat(flat1)
    );

    function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        logic [15:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    // Reference: dut0 has 8 regs, bypass on; dut1 has 6 regs, R0 hardwired to zero, no bypass
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m0[i] <= '0;
            for (int i = 0; i < 6; i++) m1[i] <= '0;
            mc <= '0;
            ms <= '0;
        end else begin
            if (we) m0[waddr] <= mrg(m0[waddr], wdata, wbe);
            if (we && int'(waddr) < 6 && waddr != 0) m1[waddr] <= mrg(m1[waddr], wdata, wbe);
            if (c_we) mc <= c_in;
            if (s_we) ms <= s_in;
        end
    end

    function automatic logic [15:0] e0(input logic [2:0] a);
        return (we && waddr == a) ? mrg(m0[a], wdata, wbe) : m0[a];
    endfunction
    function automatic logic [15:0] e1(input logic [2:0] a);
        return (a == 0 || int'(a) >= 6) ? 16'h0 : m1[a];
    endfunction
    function automatic logic [127:0] f0();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = m0[i];
        return r;
    endfunction
    function automatic logic [95:0] f1();
        logic [95:0] r;
        for (int i = 0; i < 6; i++) r[i*16 +: 16] = m1[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; we = 0; waddr = 0; wdata = 0; wbe = 0;
        c_we = 0; c_in = 0; s_we = 0; s_in = 0;
    endtask

    task automatic test_reset();
        idle();
        we = 1; wbe = 2'b11; wdata = 16'hFFFF;
        c_we = 1; c_in = 16'hFFFF; s_we = 1; s_in = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            waddr = 3'(i);
            tick();
        end
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            raddr_b = 3'(7 - i);
            #1;
            n_cmp++; if (rdata_a0 !== 16'h0) begin n_bad++; $display("FAIL reset_a0 addr=%0d got=%h exp=0000", i, rdata_a0); end
            n_cmp++; if (rdata_b0 !== 16'h0) begin n_bad++; $display("FAIL reset_b0 addr=%0d got=%h exp=0000", 7 - i, rdata_b0); end
            n_cmp++; if (rdata_a1 !== 16'h0) begin n_bad++; $display("FAIL reset_a1 addr=%0d got=%h exp=0000", i, rdata_a1); end
            n_cmp++; if (rdata_b1 !== 16'h0) begin n_bad++; $display("FAIL reset_b1 addr=%0d got=%h exp=0000", 7 - i, rdata_b1); end
        end
        n_cmp++; if (c0 !== 16'h0 || c1 !== 16'h0) begin n_bad++; $display("FAIL reset_c got=%h/%h exp=0000", c0, c1); end
        n_cmp++; if (s0 !== 16'h0 || s1 !== 16'h0) begin n_bad++; $display("FAIL reset_s got=%h/%h exp=0000", s0, s1); end
        n_cmp++; if (flat0 !== 128'h0) begin n_bad++; $display("FAIL reset_flat0 got=%h exp=0", flat0); end
        n_cmp++; if (flat1 !== 96'h0) begin n_bad++; $display("FAIL reset_flat1 got=%h exp=0", flat1); end
    endtask

    task automatic test_write_mask();
        idle();
        we = 1; waddr = 3; wdata = 16'hABCD; wbe = 2'b11;
        tick();
        idle();
        raddr_a = 3;
        #1;
        n_cmp++; if (rdata_a0 !== 16'hABCD) begin n_bad++; $display("FAIL wr_full_a0 got=%h exp=abcd", rdata_a0); end
        n_cmp++; if (rdata_a1 !== 16'hABCD) begin n_bad++; $display("FAIL wr_full_a1 got=%h exp=abcd", rdata_a1); end
        we = 1; waddr = 3; wdata = 16'h1234; wbe = 2'b01;
        tick();
        idle();
        n_cmp++; if (rdata_a0 !== 16'hAB34) begin n_bad++; $display("FAIL wr_low_a0 got=%h exp=ab34", rdata_a0); end
        n_cmp++; if (rdata_a1 !== 16'hAB34) begin n_bad++; $display("FAIL wr_low_a1 got=%h exp=ab34", rdata_a1); end
        we = 1; waddr = 3; wdata = 16'hFFFF; wbe = 2'b00;
        tick();
        idle();
        n_cmp++; if (rdata_a0 !== 16'hAB34) begin n_bad++; $display("FAIL wr_nobe_a0 got=%h exp=ab34", rdata_a0); end
        n_cmp++; if (rdata_a1 !== 16'hAB34) begin n_bad++; $display("FAIL wr_nobe_a1 got=%h exp=ab34", rdata_a1); end
    endtask

    task automatic test_bypass();
        idle();
        raddr_b = 5;
        we = 1; waddr = 5; wdata = 16'h5555; wbe = 2'b11;
        #1;
        n_cmp++; if (rdata_b0 !== 16'h5555) begin n_bad++; $display("FAIL bypass_on got=%h exp=5555", rdata_b0); end
        n_cmp++; if (rdata_b1 !== 16'h0000) begin n_bad++; $display("FAIL bypass_off got=%h exp=0000", rdata_b1); end
        tick();
        idle();
        n_cmp++; if (rdata_b1 !== 16'h5555) begin n_bad++; $display("FAIL bypass_off_post got=%h exp=5555", rdata_b1); end
        we = 1; waddr = 5; wdata = 16'hAAAA; wbe = 2'b10;
        #1;
        n_cmp++; if (rdata_b0 !== 16'hAA55) begin n_bad++; $display("FAIL bypass_merge got=%h exp=aa55", rdata_b0); end
        n_cmp++; if (rdata_b1 !== 16'h5555) begin n_bad++; $display("FAIL bypass_off_merge got=%h exp=5555", rdata_b1); end
        tick();
        idle();
    endtask

    task automatic test_zero_r0();
        idle();
        raddr_a = 0;
        we = 1; waddr = 0; wdata = 16'hBEEF; wbe = 2'b11;
        #1;
        n_cmp++; if (rdata_a1 !== 16'h0) begin n_bad++; $display("FAIL zr0_bypass got=%h exp=0000", rdata_a1); end
        n_cmp++; if (rdata_a0 !== 16'hBEEF) begin n_bad++; $display("FAIL r0_bypass got=%h exp=beef", rdata_a0); end
        tick();
        idle();
        n_cmp++; if (rdata_a1 !== 16'h0) begin n_bad++; $display("FAIL zr0_read got=%h exp=0000", rdata_a1); end
        n_cmp++; if (flat1[15:0] !== 16'h0) begin n_bad++; $display("FAIL zr0_flat got=%h exp=0000", flat1[15:0]); end
        n_cmp++; if (rdata_a0 !== 16'hBEEF) begin n_bad++; $display("FAIL r0_read got=%h exp=beef", rdata_a0); end
    endtask

    task automatic test_same_cycle();
        idle();
        c_we = 1; c_in = 16'h0001; s_we = 1; s_in = 16'h8000;
        we = 1; waddr = 7; wdata = 16'h7777; wbe = 2'b11;
        rst = 1;
        tick();
        rst = 0;
        we = 0; c_we = 0; s_we = 0;
        raddr_a = 7;
        #1;
        n_cmp++; if (c0 !== 16'h0 || s0 !== 16'h0) begin n_bad++; $display("FAIL rst_dom_cs got=%h/%h exp=0000/0000", c0, s0); end
        n_cmp++; if (rdata_a0 !== 16'h0) begin n_bad++; $display("FAIL rst_dom_r7 got=%h exp=0000", rdata_a0); end
        n_cmp++; if (flat0 !== 128'h0) begin n_bad++; $display("FAIL rst_dom_flat got=%h exp=0", flat0); end
        we = 1; c_we = 1; s_we = 1;
        tick();
        idle();
        n_cmp++; if (c0 !== 16'h0001 || c1 !== 16'h0001) begin n_bad++; $display("FAIL same_c got=%h/%h exp=0001", c0, c1); end
        n_cmp++; if (s0 !== 16'h8000 || s1 !== 16'h8000) begin n_bad++; $display("FAIL same_s got=%h/%h exp=8000", s0, s1); end
        n_cmp++; if (rdata_a0 !== 16'h7777) begin n_bad++; $display("FAIL same_r7 got=%h exp=7777", rdata_a0); end
        n_cmp++; if (rdata_a1 !== 16'h0) begin n_bad++; $display("FAIL same_r7_inv got=%h exp=0000", rdata_a1); end
        n_cmp++; if (flat1 !== 96'h0) begin n_bad++; $display("FAIL same_flat1 got=%h exp=0", flat1); end
    endtask

    task automatic test_invalid();
        idle();
        we = 1; waddr = 2; wdata = 16'h2222; wbe = 2'b11;
        tick();
        we = 1; waddr = 7; wdata = 16'h1111;
        tick();
        waddr = 6;
        tick();
        idle();
        raddr_a = 6;
        raddr_b = 7;
        #1;
        n_cmp++; if (flat1 !== 96'h0000_0000_0000_2222_0000_0000) begin n_bad++; $display("FAIL inv_flat1 got=%h exp=000000000000222200000000", flat1); end
        n_cmp++; if (rdata_a1 !== 16'h0 || rdata_b1 !== 16'h0) begin n_bad++; $display("FAIL inv_read got=%h/%h exp=0000", rdata_a1, rdata_b1); end
        n_cmp++; if (rdata_a0 !== 16'h1111 || rdata_b0 !== 16'h1111) begin n_bad++; $display("FAIL r6r7_dut0 got=%h/%h exp=1111", rdata_a0, rdata_b0); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 3) != 0);
            waddr = 3'($urandom);
            wdata = 16'($urandom);
            wbe = 2'($urandom);
            raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom);
            raddr_b = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom);
            c_we = 1'($urandom); c_in = 16'($urandom);
            s_we = 1'($urandom); s_in = 16'($urandom);
            #1;
            if (!rst) begin
                n_cmp++; if (rdata_a0 !== e0(raddr_a)) begin n_bad++; $display("FAIL rnd_a0 it=%0d addr=%0d got=%h exp=%h", n, raddr_a, rdata_a0, e0(raddr_a)); end
                n_cmp++; if (rdata_b0 !== e0(raddr_b)) begin n_bad++; $display("FAIL rnd_b0 it=%0d addr=%0d got=%h exp=%h", n, raddr_b, rdata_b0, e0(raddr_b)); end
                n_cmp++; if (rdata_a1 !== e1(raddr_a)) begin n_bad++; $display("FAIL rnd_a1 it=%0d addr=%0d got=%h exp=%h", n, raddr_a, rdata_a1, e1(raddr_a)); end
                n_cmp++; if (rdata_b1 !== e1(raddr_b)) begin n_bad++; $display("FAIL rnd_b1 it=%0d addr=%0d got=%h exp=%h", n, raddr_b, rdata_b1, e1(raddr_b)); end
            end
            tick();
            n_cmp++; if (flat0 !== f0()) begin n_bad++; $display("FAIL rnd_flat0 it=%0d got=%h exp=%h", n, flat0, f0()); end
            n_cmp++; if (flat1 !== f1()) begin n_bad++; $display("FAIL rnd_flat1 it=%0d got=%h exp=%h", n, flat1, f1()); end
            n_cmp++; if (c0 !== mc || c1 !== mc) begin n_bad++; $display("FAIL rnd_c it=%0d got=%h/%h exp=%h", n, c0, c1, mc); end
            n_cmp++; if (s0 !== ms || s1 !== ms) begin n_bad++; $display("FAIL rnd_s it=%0d got=%h/%h exp=%h", n, s0, s1, ms); end
        end
        idle();
    endtask

    initial begin
        idle();
        raddr_a = 0;
        raddr_b = 0;
        test_reset();
        test_write_mask();
        test_bypass();
        test_zero_r0();
        test_same_cycle();
        test_invalid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
